// File: rtl/gcd_scheduler.sv
// gcd_scheduler: round-robin arbiter sharing one subtractive GCD engine between N_REQ requesters,
// with a zero-operand bypass and a WAIT watchdog.
module gcd_scheduler #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]       res,
    output logic                        err,
    output logic                        busy,
    output logic                        eng_start,
    output logic [DATA_WIDTH-1:0]       eng_a,
    output logic [DATA_WIDTH-1:0]       eng_b,
    input  logic                        eng_done,
    input  logic [DATA_WIDTH-1:0]       eng_res
);
    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d, grant_q, grant_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  err_q, err_d;
    logic                  found;
    logic [IW-1:0]         pick, cand;
    logic [DATA_WIDTH-1:0] a_arr [N_REQ];
    logic [DATA_WIDTH-1:0] b_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        assign b_arr[i] = req_b[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // First pending request at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IW'((int'(ptr_q) + i) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        a_d     = a_q;
        b_d     = b_q;
        timer_d = timer_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (found) begin
                grant_d = pick;
                a_d     = a_arr[pick];
                b_d     = b_arr[pick];
                timer_d = '0;
                if (a_d == '0 || b_d == '0) begin
                    res_d   = a_d | b_d;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: state_d = WAIT;
            WAIT: if (eng_done) begin
                res_d   = eng_res;
                err_d   = 1'b0;
                state_d = RESP;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
                res_d   = '0;
                err_d   = 1'b1;
                state_d = RESP;
            end else begin
                timer_d = timer_q + 1'b1;
            end
            RESP: begin
                ptr_d   = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            timer_q <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            timer_q <= timer_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign ack       = {{(N_REQ-1){1'b0}}, state_q == RESP} << grant_q;
    assign res       = (state_q == RESP) ? res_q : '0;
    assign err       = (state_q == RESP) && err_q;
    assign busy      = state_q != IDLE;
    assign eng_start = state_q == LAUNCH;
    assign eng_a     = a_q;
    assign eng_b     = b_q;
endmodule

// File: doc/gcd_scheduler.md
# gcd_scheduler

Round-robin scheduler that shares one subtractive GCD engine (datapath plus its controller) between `N_REQ` requesters. It arbitrates pending requests, launches the engine with the granted requester's operands, and waits for completion. It returns the result to that requester with a one-cycle acknowledge, with a watchdog and a zero-operand bypass. It sits between the client blocks and the single GCD engine instance.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: operand/result width.
- `TIMEOUT`, 1024: maximum WAIT cycles before abort, ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `n_rst`  in  1  asynchronous active-low reset.
- `req`  in  N_REQ  request per requester, level.
- `req_a`  in  N_REQ*DATA_WIDTH  operand A, requester i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_b`  in  N_REQ*DATA_WIDTH  operand B, same packing.
- `ack`  out  N_REQ  one-hot one-cycle pulse, result valid for requester i.
- `res`  out  DATA_WIDTH  result; valid only while `ack` ≠ 0, else 0.
- `err`  out  1  timeout flag; valid with `ack`.
- `busy`  out  1  high in any state other than IDLE.
- `eng_start`  out  1  one-cycle launch pulse to engine.
- `eng_a`, `eng_b`  out  DATA_WIDTH each  operands to engine; stable from LAUNCH through WAIT.
- `eng_done`  in  1  engine completion pulse, `eng_res` valid same cycle.
- `eng_res`  in  DATA_WIDTH  engine result.

## Operation
- States: IDLE, LAUNCH, WAIT, RESP. All outputs decode from registered state and registers only; no input-to-output combinational path.
- IDLE:
  - If `req` = 0, stay.
  - Otherwise grant the first set bit searching `ptr, ptr+1, …` with wrap modulo N_REQ.
  - Latch the grant index, that requester's A and B, and clear the timer.
  - If A = 0 or B = 0, load result = A|B (gcd(x,0)=x, gcd(0,0)=0) and err=0, then go to RESP (bypass; engine untouched).
  - Else go to LAUNCH.
- LAUNCH: `eng_start`=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - If `eng_done`=1, capture `eng_res` with err=0 and go to RESP.
  - Else if timer = TIMEOUT-1, set result=0, err=1 and go to RESP.
  - Else increment the timer.
  - `eng_done` and timeout in the same cycle: done wins.
- RESP:
  - `ack[grant]`=1, `res`/`err` driven from registers.
  - `ptr` ← (grant+1) mod N_REQ, then go to IDLE.
- `eng_done` outside WAIT is ignored.
- Requester protocol:
  - Hold `req` and operands stable until it samples `ack`=1.
  - Deassert `req` at that same edge.
  - Operand changes while `req` is high and before the grant are allowed; the latched values are used after the grant.
- `req` is sampled only in IDLE; requests arriving during service wait.

## Timing
- Reset values: state IDLE, `ptr`=0, timer=0, and all outputs (`ack`, `res`, `err`, `busy`, `eng_start`, `eng_a`, `eng_b`) 0.
- Reset mid-operation aborts immediately with no `ack`. The engine shares `n_rst`.
- Normal path latency:
  - `req` seen in IDLE at cycle 0: LAUNCH at 1, WAIT from 2.
  - `eng_done` at cycle k: `ack` at k+1.
  - The next grant can occur at k+2.
- Bypass path: `ack` at cycle 1, with `eng_start` never asserted.
- Timeout path: `ack` with err=1 exactly TIMEOUT cycles after entering WAIT.
- `busy` rises the cycle after grant and falls when re-entering IDLE.

## Test plan
- Single request: requester 0 sends A=48, B=18; engine model returns 6 after 10 cycles → exactly one `eng_start` pulse, `eng_a`=48 and `eng_b`=18 stable through WAIT, then `ack`=0001 for one cycle with `res`=6 and `err`=0.
- All four `req` high continuously with distinct operands → grants in order 0,1,2,3,0, each with one `ack` pulse and the matching result.
- Round-robin wrap: after serving 2 (`ptr`=3), `req`=1001 → requester 3 served before 0.
- Bypass: A=0, B=9 → `res`=9, no `eng_start`, `ack` one cycle after IDLE sample. Also A=0, B=0 → `res`=0.
- Timeout: TIMEOUT=16, engine never asserts done → `ack` with `err`=1 and `res`=0 exactly 16 cycles after WAIT entry. Variant with `eng_done` on the final cycle → `err`=0 and `res`=`eng_res`.
- Reset mid-WAIT: assert `n_rst`=0 → all outputs 0 with no `ack`. After release, a new request to requester 2 is served normally (`ptr` restarted at 0).
